// File: rtl/l1d_mshr_data_ram_rr_arb.sv
// l1d_mshr_data_ram_rr_arb
// Merges the MSHR bypass request and NUM_ENTRY MSHR entry requests onto the
// single L1D data-RAM request port. Bypass has priority. Entries share the port
// round-robin. A starvation counter limits how long bypass can lock entries out.
// The port is driven from a registered valid/ready output stage.
module l1d_mshr_data_ram_rr_arb #(
  parameter  int NUM_ENTRY  = 8,
  parameter  int STARVE_MAX = 4,
  parameter  int DATA_W     = 32,
  localparam int SRC_W      = $clog2(NUM_ENTRY + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mshr_bps_vld,
  input  logic [DATA_W-1:0]             mshr_bps_pld,
  output logic                          mshr_bps_rdy,
  input  logic [NUM_ENTRY-1:0]          mshr_entry_vld,
  input  logic [NUM_ENTRY*DATA_W-1:0]   mshr_entry_pld,
  output logic [NUM_ENTRY-1:0]          mshr_entry_rdy,
  output logic                          data_ram_vld,
  output logic [DATA_W-1:0]             data_ram_pld,
  output logic [SRC_W-1:0]              data_ram_src,
  input  logic                          data_ram_rdy
);

  localparam int PTR_W = $clog2(NUM_ENTRY);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  starve_cnt;

  logic              load;
  logic              any_entry;
  logic              force_entry;
  logic              bps_win_p0;
  logic              ent_win_p0;
  logic [PTR_W-1:0]  ent_idx_p0;
  logic [PTR_W-1:0]  cand_p0;
  logic              win_vld_p0;
  logic [DATA_W-1:0] win_pld_p0;
  logic [SRC_W-1:0]  win_src_p0;

  // Saturating increment of the starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= CNT_W'(STARVE_MAX)) sat_inc = CNT_W'(STARVE_MAX);
    else                           sat_inc = cnt + CNT_W'(1);
  endfunction

  // Next round-robin pointer: one past the granted entry, wrapping to 0.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] idx);
    if (idx == PTR_W'(NUM_ENTRY - 1)) ptr_next = '0;
    else                              ptr_next = idx + PTR_W'(1);
  endfunction

  // ---- stage p0: combinational arbitration ----

  assign load        = !data_ram_vld || data_ram_rdy;
  assign any_entry   = |mshr_entry_vld;
  assign force_entry = (starve_cnt == CNT_W'(STARVE_MAX)) && any_entry;
  assign bps_win_p0  = mshr_bps_vld && !force_entry;

  // Round-robin scan: first valid entry starting at rr_ptr, wrapping.
  always_comb begin
    ent_win_p0 = 1'b0;
    ent_idx_p0 = '0;
    cand_p0    = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      cand_p0 = PTR_W'((int'(rr_ptr) + i) % NUM_ENTRY);
      if (!ent_win_p0 && mshr_entry_vld[cand_p0]) begin
        ent_win_p0 = 1'b1;
        ent_idx_p0 = cand_p0;
      end
    end
  end

  // Winner payload/source and the grant strobes back to the requesters.
  always_comb begin
    win_vld_p0     = bps_win_p0 || ent_win_p0;
    win_pld_p0     = mshr_entry_pld[ent_idx_p0*DATA_W +: DATA_W];
    win_src_p0     = SRC_W'(ent_idx_p0) + SRC_W'(1);
    mshr_bps_rdy   = 1'b0;
    mshr_entry_rdy = '0;
    if (bps_win_p0) begin
      win_pld_p0   = mshr_bps_pld;
      win_src_p0   = '0;
      mshr_bps_rdy = load;
    end else if (ent_win_p0) begin
      mshr_entry_rdy[ent_idx_p0] = load;
    end
  end

  // ---- stage p1: registered output to the data RAM ----

  // Output register loads the winner whenever the slot is empty or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_ram_vld <= 1'b0;
      data_ram_pld <= '0;
      data_ram_src <= '0;
    end else if (load) begin
      data_ram_vld <= win_vld_p0;
      if (win_vld_p0) begin
        data_ram_pld <= win_pld_p0;
        data_ram_src <= win_src_p0;
      end
    end
  end

  // Round-robin pointer advances only on an entry grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (load && !bps_win_p0 && ent_win_p0) begin
      rr_ptr <= ptr_next(ent_idx_p0);
    end
  end

  // Counts bypass wins that blocked a pending entry; cleared when entries get through or go idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!any_entry) begin
      starve_cnt <= '0;
    end else if (load) begin
      if (bps_win_p0) starve_cnt <= sat_inc(starve_cnt);
      else            starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_l1d_mshr_data_ram_rr_arb.sv
// Directed bench for l1d_mshr_data_ram_rr_arb (NUM_ENTRY=8, STARVE_MAX=4, 16-bit payload).
module tb_l1d_mshr_data_ram_rr_arb;

  localparam int NE = 8;
  localparam int DW = 16;
  localparam int SW = $clog2(NE + 1);

  logic              clk;
  logic              rst_n;
  logic              mshr_bps_vld;
  logic [DW-1:0]     mshr_bps_pld;
  logic              mshr_bps_rdy;
  logic [NE-1:0]     mshr_entry_vld;
  logic [NE*DW-1:0]  mshr_entry_pld;
  logic [NE-1:0]     mshr_entry_rdy;
  logic              data_ram_vld;
  logic [DW-1:0]     data_ram_pld;
  logic [SW-1:0]     data_ram_src;
  logic              data_ram_rdy;

  int errors = 0;
  int checks = 0;

  l1d_mshr_data_ram_rr_arb #(
    .NUM_ENTRY (NE),
    .STARVE_MAX(4),
    .DATA_W    (DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mshr_bps_vld  (mshr_bps_vld),
    .mshr_bps_pld  (mshr_bps_pld),
    .mshr_bps_rdy  (mshr_bps_rdy),
    .mshr_entry_vld(mshr_entry_vld),
    .mshr_entry_pld(mshr_entry_pld),
    .mshr_entry_rdy(mshr_entry_rdy),
    .data_ram_vld  (data_ram_vld),
    .data_ram_pld  (data_ram_pld),
    .data_ram_src  (data_ram_src),
    .data_ram_rdy  (data_ram_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1ns after the active edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check the registered output triple.
  task automatic chk_out(input string tag, input logic vld, input logic [31:0] src, input logic [31:0] pld);
    chk({tag, "_vld"}, {31'd0, data_ram_vld}, {31'd0, vld});
    chk({tag, "_src"}, 32'(data_ram_src), src);
    chk({tag, "_pld"}, 32'(data_ram_pld), pld);
  endtask

  // Check the combinational grant strobes.
  task automatic chk_rdy(input string tag, input logic bps, input logic [31:0] ent);
    chk({tag, "_bps_rdy"}, {31'd0, mshr_bps_rdy}, {31'd0, bps});
    chk({tag, "_ent_rdy"}, 32'(mshr_entry_rdy), ent);
  endtask

  initial begin
    rst_n          = 1'b1;
    mshr_bps_vld   = 1'b0;
    mshr_bps_pld   = 16'hB000;
    mshr_entry_vld = '0;
    data_ram_rdy   = 1'b1;
    for (int k = 0; k < NE; k++) mshr_entry_pld[k*DW +: DW] = DW'(16'hE000 + k);

    // Reset state
    #3 rst_n = 1'b0;
    #1 chk_out("reset", 1'b0, 0, 0);
    repeat (2) cyc();
    rst_n = 1'b1;

    // Round-robin across all eight entries, then wrap back to entry 0
    mshr_entry_vld = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      #1 chk_rdy("rr", 1'b0, 32'(1) << (i % NE));
      cyc();
      chk_out("rr", 1'b1, (i % NE) + 1, 32'hE000 + (i % NE));
    end
    // rr_ptr=1, starve_cnt=0

    // Bypass beats a simultaneous entry request; entry 2 follows once bypass drops
    mshr_entry_vld = 8'h04;
    mshr_bps_vld   = 1'b1;
    mshr_bps_pld   = 16'hB001;
    #1 chk_rdy("prio_bps", 1'b1, 0);
    cyc();
    chk_out("prio_bps", 1'b1, 0, 32'hB001);
    mshr_bps_vld = 1'b0;
    #1 chk_rdy("prio_ent", 1'b0, 32'h04);
    cyc();
    chk_out("prio_ent", 1'b1, 3, 32'hE002);
    // Idle cycle drains the output
    mshr_entry_vld = '0;
    cyc();
    chk("idle_vld", {31'd0, data_ram_vld}, 0);

    // Anti-starvation: bypass held, entry 0 pending -> 0,0,0,0,1,0
    mshr_bps_vld   = 1'b1;
    mshr_bps_pld   = 16'hB002;
    mshr_entry_vld = 8'h01;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i == 4) chk_rdy("starve_force", 1'b0, 32'h01);
      else        chk_rdy("starve_bps", 1'b1, 0);
      cyc();
      if (i == 4) chk_out("starve_force", 1'b1, 1, 32'hE000);
      else        chk_out("starve_bps", 1'b1, 0, 32'hB002);
    end
    // starve_cnt=1, rr_ptr=1, output holds bypass B002

    // Back-pressure: three stalled cycles hold everything
    data_ram_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk_rdy("bp_stall", 1'b0, 0);
      cyc();
      chk_out("bp_stall", 1'b1, 0, 32'hB002);
    end
    // Release: pending bypass granted at once; starve_cnt resumes from 1 -> forced on 4th
    data_ram_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 3) chk_rdy("bp_force", 1'b0, 32'h01);
      else        chk_rdy("bp_bps", 1'b1, 0);
      cyc();
      if (i == 3) chk_out("bp_force", 1'b1, 1, 32'hE000);
      else        chk_out("bp_bps", 1'b1, 0, 32'hB002);
    end
    // rr_ptr=1, starve_cnt=0

    // Wrap: only entry 7 valid -> granted, rr_ptr wraps to 0
    mshr_bps_vld   = 1'b0;
    mshr_entry_vld = 8'h80;
    #1 chk_rdy("wrap", 1'b0, 32'h80);
    cyc();
    chk_out("wrap", 1'b1, 8, 32'hE007);
    // Bubble: no requests -> valid drops, payload/source hold
    mshr_entry_vld = '0;
    #1 chk_rdy("bubble", 1'b0, 0);
    cyc();
    chk_out("bubble", 1'b0, 8, 32'hE007);
    // All valid: scan must start at entry 0 after the wrap
    mshr_entry_vld = 8'hFF;
    #1 chk_rdy("after_wrap", 1'b0, 32'h01);
    cyc();
    chk_out("after_wrap", 1'b1, 1, 32'hE000);
    // rr_ptr=1 now; output full

    // Asynchronous reset mid-cycle discards the in-flight request
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 1'b0, 0, 0);
    #1 rst_n = 1'b1;
    #1 chk_rdy("post_rst", 1'b0, 32'h01);
    cyc();
    chk_out("post_rst", 1'b1, 1, 32'hE000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
